alu_wide_sequencer: RTL and testbench
=====================================

Name: alu_wide_sequencer

Overview:
- Initiator/driver side of the 32-bit combinational ALU: accepts wide (W*NWORDS-bit) operation requests over a valid/ready handshake.
- Issues one ALU pass per W-bit word, least-significant word first, and chains the adder carry between passes.
- Assembles the wide result and flags into a held response register for the consumer.
- Sits between the datapath controller and the ALU instance.

Parameters:
- W, 32, ALU word width; must match the ALU instance.
- NWORDS, 2, ALU passes per request; legal range 1..8.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  3  opcode, same encoding as the ALU Op: 0 XOR, 1 AND, 2 OR, 3 (~A)|B, 4 ADD, 5/6 shift, 7 zero
- req_a  input  W*NWORDS  operand A
- req_b  input  W*NWORDS  operand B
- req_cin  input  1  carry-in, used only for ADD
- alu_a  output  W  ALU operand A word
- alu_b  output  W  ALU operand B word
- alu_cin  output  1  ALU carry-in
- alu_op  output  3  ALU opcode
- alu_sum  input  W  ALU result word
- alu_status  input  2  ALU Status; bit1 = zero, bit0 ignored
- alu_status2  input  2  ALU Status2; bit0 = adder carry-out, bit1 ignored
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer takes response
- rsp_sum  output  W*NWORDS  wide result
- rsp_carry  output  1  final carry-out; ADD only, else 0
- rsp_zero  output  1  wide result is all zero
- rsp_neg  output  1  MSB of rsp_sum
- rsp_ovf  output  1  signed overflow; ADD only, else 0
- rsp_err  output  1  unsupported opcode (5 or 6)

Behaviour:
- Reset values:
  - State = IDLE; word index = 0.
  - req_ready = 1 once out of reset; rsp_valid = 0.
  - rsp_* outputs = 0; alu_a, alu_b, alu_cin, alu_op = 0.
- States:
  - IDLE: req_ready = 1.
    - On req_valid & req_ready, latch op/a/b/cin.
    - Opcode 5 or 6: go to DONE with rsp_err = 1, rsp_sum = 0, all other flags 0. No ALU pass is issued.
    - Any other opcode: clear index and go to EXEC.
  - EXEC: req_ready = 0.
    - alu_a, alu_b = latched operand word [index]; alu_op = latched op. These are driven from registers, so they are stable for the whole cycle.
    - alu_cin: for ADD, = latched cin when index = 0, else the registered carry from the previous pass. For non-ADD ops, alu_cin = 0.
    - At the clock edge: capture alu_sum into result word [index] and register alu_status2[0] as the chain carry. AND alu_status[1] into a running zero flag, which is initialised to 1 on accept.
    - Index increments each pass; after pass NWORDS-1, go to DONE.
  - DONE: rsp_valid = 1 and all rsp_* held stable until rsp_ready. On rsp_valid & rsp_ready, return to IDLE.
  - alu_* outputs return to 0 in IDLE and DONE.
- Latency: an accepted legal request at edge 0 gives rsp_valid from cycle NWORDS+1. An err request gives rsp_valid from cycle 1.
- Throughput: one request per NWORDS+2 cycles with rsp_ready tied high. There is no overlap; req_ready is low in EXEC and DONE.
- Flags:
  - rsp_carry = carry from the last pass (ADD only).
  - rsp_ovf = (a_msb == b_msb) & (sum_msb != a_msb), for ADD only, computed locally. ALU Status bit0 is not used.
  - rsp_neg = rsp_sum[W*NWORDS-1] for every non-err op.
- Op 7 runs the normal pass sequence: result 0, rsp_zero = 1.
- req_valid while not ready: ignored, no latch; the requester must hold.
- Reset mid-EXEC or in DONE: abandons the operation next edge; no response is produced.

Optional Feature:
- Macro ALU_SEQ_STICKY_EN.
- When defined, the block adds:
  - Input sticky_clr (1 bit).
  - Output sticky_ovf (1 bit), reset 0.
- sticky_ovf sets on any response handshake with rsp_ovf = 1. It clears on sticky_clr. If sticky_clr and a setting handshake occur in the same cycle, the set wins.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ADD low-word carry: a=0x00000000_FFFFFFFF, b=0x1, cin=0, NWORDS=2 -> alu_cin=1 on pass 2; rsp_sum=0x00000001_00000000, carry=0, zero=0, ovf=0; rsp_valid at cycle 3.
- Signed overflow and wrap: a=0x7FFFFFFF_FFFFFFFF, b=0x1 -> rsp_sum=0x80000000_00000000, ovf=1, neg=1, carry=0. Then a=b=0xFFFFFFFF_FFFFFFFF, cin=1 -> sum=0xFFFFFFFF_FFFFFFFF, carry=1, ovf=0.
- Logic op zero: op=1 AND, a=0xF0F0F0F0_0F0F0F0F, b=~a -> rsp_sum=0, zero=1, carry=0, alu_cin=0 on both passes.
- Unsupported op: op=5 -> rsp_valid at cycle 1, err=1, sum=0, no ALU pass (alu_op stays 0).
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, req_ready=0, new req_valid ignored. Then rsp_ready=1 -> IDLE next edge.
- Reset mid-EXEC during pass 1 -> next cycle IDLE, rsp_valid=0, alu_* = 0. With ALU_SEQ_STICKY_EN, an overflow ADD sets sticky_ovf; sticky_clr coincident with a new overflow handshake leaves it set.

Source files
------------

// File: rtl/alu_wide_sequencer_if.sv
// Request, ALU-pass and response signals of the wide ALU sequencer.
// master = sequencer side, slave = controller/ALU side.
interface alu_wide_sequencer_if #(
  parameter int W      = 32,
  parameter int NWORDS = 2
);
  localparam int WW = W * NWORDS;

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [WW-1:0] req_a;
  logic [WW-1:0] req_b;
  logic          req_cin;

  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_cin;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_sum;
  logic [1:0]    alu_status;
  logic [1:0]    alu_status2;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [WW-1:0] rsp_sum;
  logic          rsp_carry;
  logic          rsp_zero;
  logic          rsp_neg;
  logic          rsp_ovf;
  logic          rsp_err;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_cin,
    input  alu_sum, alu_status, alu_status2,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_cin, alu_op,
    output rsp_valid, rsp_sum, rsp_carry,
    output rsp_zero, rsp_neg, rsp_ovf, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_cin,
    output alu_sum, alu_status, alu_status2,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_cin, alu_op,
    input  rsp_valid, rsp_sum, rsp_carry,
    input  rsp_zero, rsp_neg, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_wide_sequencer.sv
// Wide-operand driver for the 32-bit ALU: one pass per word, LSW first.
// Optional sticky overflow flag behind `ALU_SEQ_STICKY_EN.
module alu_wide_sequencer #(
  parameter int W      = 32,
  parameter int NWORDS = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef ALU_SEQ_STICKY_EN
  input  logic sticky_clr,
  output logic sticky_ovf,
`endif
  alu_wide_sequencer_if.master bus
);
  localparam int WW = W * NWORDS;
  localparam int IW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] OP_ADD = 3'd4;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    op_q;
  logic [WW-1:0] a_q, b_q, res_q;
  logic          cin_q, carry_q, zacc_q;
  logic          cout_q, zero_q, ovf_q, err_q;

  logic idle, exec, done, last, is_add;
  logic accept, bad_op, rsp_fire;
  int   base;
  logic unused_bits;

  assign idle     = state_q == S_IDLE;
  assign exec     = state_q == S_EXEC;
  assign done     = state_q == S_DONE;
  assign last     = idx_q == IW'(NWORDS - 1);
  assign is_add   = op_q == OP_ADD;
  assign accept   = bus.req_valid & idle;
  assign bad_op   = (bus.req_op == 3'd5) |
                    (bus.req_op == 3'd6);
  assign rsp_fire = done & bus.rsp_ready;
  assign base     = W * int'(idx_q);

  assign unused_bits = ^{bus.alu_status[0],
                         bus.alu_status2[1]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (1'b1)
      idle: if (accept) begin
        state_d = bad_op ? S_DONE : S_EXEC;
        idx_d   = '0;
      end
      exec: begin
        if (last) state_d = S_DONE;
        else      idx_d   = idx_q + IW'(1);
      end
      done: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        op_q   <= bus.req_op;
        a_q    <= bus.req_a;
        b_q    <= bus.req_b;
        cin_q  <= bus.req_cin;
        zacc_q <= 1'b1;
        res_q  <= '0;
        cout_q <= 1'b0;
        zero_q <= 1'b0;
        ovf_q  <= 1'b0;
        err_q  <= bad_op;
      end
      if (exec) begin
        res_q[base +: W] <= bus.alu_sum;
        carry_q <= bus.alu_status2[0];
        zacc_q  <= zacc_q & bus.alu_status[1];
        // Flags settle on the final (most-significant) pass
        if (last) begin
          cout_q <= is_add & bus.alu_status2[0];
          zero_q <= zacc_q & bus.alu_status[1];
          ovf_q  <= is_add &
                    (a_q[WW-1] == b_q[WW-1]) &
                    (bus.alu_sum[W-1] != a_q[WW-1]);
        end
      end
    end
  end

  assign bus.req_ready = idle;

  assign bus.alu_a   = exec ? a_q[base +: W] : '0;
  assign bus.alu_b   = exec ? b_q[base +: W] : '0;
  assign bus.alu_op  = exec ? op_q : 3'd0;
  assign bus.alu_cin = exec & is_add &
                       ((idx_q == '0) ? cin_q : carry_q);

  assign bus.rsp_valid = done;
  assign bus.rsp_sum   = res_q;
  assign bus.rsp_carry = cout_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_neg   = res_q[WW-1];
  assign bus.rsp_ovf   = ovf_q;
  assign bus.rsp_err   = err_q;

`ifdef ALU_SEQ_STICKY_EN
  logic sticky_q;

  // A setting handshake beats a coincident clear
  always_ff @(posedge clk) begin
    if (reset)                   sticky_q <= 1'b0;
    else if (rsp_fire & ovf_q)   sticky_q <= 1'b1;
    else if (sticky_clr)         sticky_q <= 1'b0;
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer: ALU model, vector table, scoreboard,
// backpressure / reset corner sequences (sticky flag when enabled).
module tb_alu_wide_sequencer;
  localparam int NW = 2;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        c;
    logic        z;
    logic        n;
    logic        o;
    logic        e;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t sb[$];
  vec_t tbl[12];

  alu_wide_sequencer_if #(.W(32), .NWORDS(NW)) bus ();

`ifdef ALU_SEQ_STICKY_EN
  logic sticky_clr;
  logic sticky_ovf;
`endif

  alu_wide_sequencer #(.W(32), .NWORDS(NW)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ALU_SEQ_STICKY_EN
    .sticky_clr(sticky_clr),
    .sticky_ovf(sticky_ovf),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU; carry-out is garbage (1) for non-ADD ops
  logic [32:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (bus.alu_op)
      3'd0: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
      3'd1: alu_t = {1'b0, bus.alu_a & bus.alu_b};
      3'd2: alu_t = {1'b0, bus.alu_a | bus.alu_b};
      3'd3: alu_t = {1'b0, ~bus.alu_a | bus.alu_b};
      3'd4: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
                    + {32'd0, bus.alu_cin};
      3'd7: alu_t = '0;
      default: alu_t = {1'b1, 32'hDEADBEEF};
    endcase
  end
  assign bus.alu_sum     = alu_t[31:0];
  assign bus.alu_status  = {alu_t[31:0] == 32'd0, 1'b1};
  assign bus.alu_status2 = {1'b1,
                            (bus.alu_op == 3'd4) ? alu_t[32] : 1'b1};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int hold);
    int          lat;
    logic [32:0] lo;
    vec_t        e;
    e   = v;
    lat = 0;
    while (!bus.req_ready && lat < 40) begin
      tick();
      lat++;
    end
    chk("req_ready", bus.req_ready, 64'd1);
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_cin   = v.cin;
    sb.push_back(v);
    tick();
    bus.req_valid = 1'b0;
    lo = {1'b0, v.a[31:0]} + {1'b0, v.b[31:0]} + {32'd0, v.cin};
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      if (lat == 1) begin
        chk("p0_op", bus.alu_op, v.op);
        chk("p0_a", bus.alu_a, v.a[31:0]);
        chk("p0_b", bus.alu_b, v.b[31:0]);
        chk("p0_cin", bus.alu_cin, (v.op == 3'd4) ? v.cin : 1'b0);
      end
      if (lat == 2) begin
        chk("p1_a", bus.alu_a, v.a[63:32]);
        chk("p1_b", bus.alu_b, v.b[63:32]);
        chk("p1_cin", bus.alu_cin, (v.op == 3'd4) ? lo[32] : 1'b0);
      end
      tick();
      lat++;
    end
    chk("latency", 64'(lat), v.e ? 64'd1 : 64'(NW + 1));
    if (v.e) begin
      chk("err_alu_op", bus.alu_op, 64'd0);
      chk("err_alu_a", bus.alu_a, 64'd0);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got response expected none");
    end else begin
      e = sb.pop_front();
      chk("sum", bus.rsp_sum, e.sum);
      chk("carry", bus.rsp_carry, e.c);
      chk("zero", bus.rsp_zero, e.z);
      chk("neg", bus.rsp_neg, e.n);
      chk("ovf", bus.rsp_ovf, e.o);
      chk("err", bus.rsp_err, e.e);
    end
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd4;
        bus.req_a     = 64'd1;
        bus.req_b     = 64'd1;
        tick();
        chk("bp_valid", bus.rsp_valid, 64'd1);
        chk("bp_req_ready", bus.req_ready, 64'd0);
        chk("bp_sum", bus.rsp_sum, e.sum);
        chk("bp_ovf", bus.rsp_ovf, e.o);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      chk("bp_release_valid", bus.rsp_valid, 64'd0);
      chk("bp_release_ready", bus.req_ready, 64'd1);
    end else begin
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        r;
    logic [64:0] s;
    n_cmp = 0;
    n_bad = 0;
    tbl[0]  = '{3'd4, 64'h00000000_FFFFFFFF, 64'h1, 1'b0,
                64'h00000001_00000000, 0, 0, 0, 0, 0};
    tbl[1]  = '{3'd4, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0,
                64'h80000000_00000000, 0, 0, 1, 1, 0};
    tbl[2]  = '{3'd4, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
                64'hFFFFFFFF_FFFFFFFF, 1, 0, 1, 0, 0};
    tbl[3]  = '{3'd1, 64'hF0F0F0F0_0F0F0F0F, 64'h0F0F0F0F_F0F0F0F0, 1'b0,
                64'h0, 0, 1, 0, 0, 0};
    tbl[4]  = '{3'd5, 64'h12345678_9ABCDEF0, 64'h1, 1'b1,
                64'h0, 0, 0, 0, 0, 1};
    tbl[5]  = '{3'd6, 64'hFFFFFFFF_FFFFFFFF, 64'h3, 1'b0,
                64'h0, 0, 0, 0, 0, 1};
    tbl[6]  = '{3'd7, 64'hCAFEBABE_DEADBEEF, 64'h5555AAAA_1234ABCD, 1'b1,
                64'h0, 0, 1, 0, 0, 0};
    tbl[7]  = '{3'd0, 64'h12345678_9ABCDEF0, 64'hFFFFFFFF_00000000, 1'b0,
                64'hEDCBA987_9ABCDEF0, 0, 0, 1, 0, 0};
    tbl[8]  = '{3'd2, 64'h0, 64'h0, 1'b0,
                64'h0, 0, 1, 0, 0, 0};
    tbl[9]  = '{3'd3, 64'hFFFFFFFF_00000000, 64'h0, 1'b0,
                64'h00000000_FFFFFFFF, 0, 0, 0, 0, 0};
    tbl[10] = '{3'd4, 64'h0, 64'h0, 1'b1,
                64'h1, 0, 0, 0, 0, 0};
    tbl[11] = '{3'd4, 64'h80000000_00000000, 64'h80000000_00000000, 1'b0,
                64'h0, 1, 1, 0, 1, 0};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_EN
    sticky_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_rsp_valid", bus.rsp_valid, 64'd0);
    chk("rst_req_ready", bus.req_ready, 64'd1);
    chk("rst_rsp_sum", bus.rsp_sum, 64'd0);
    chk("rst_flags", {bus.rsp_carry, bus.rsp_zero, bus.rsp_neg,
                      bus.rsp_ovf, bus.rsp_err}, 64'd0);
    chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op},
        64'd0);
`ifdef ALU_SEQ_STICKY_EN
    chk("rst_sticky", sticky_ovf, 64'd0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run(tbl[i], 0);

    for (int i = 0; i < 4; i++) begin
      r.op  = 3'd4;
      r.a   = {$urandom, $urandom};
      r.b   = {$urandom, $urandom};
      r.cin = 1'($urandom_range(0, 1));
      s     = {1'b0, r.a} + {1'b0, r.b} + {64'd0, r.cin};
      r.sum = s[63:0];
      r.c   = s[64];
      r.z   = (s[63:0] == 64'd0);
      r.n   = s[63];
      r.o   = (r.a[63] == r.b[63]) && (s[63] != r.a[63]);
      r.e   = 1'b0;
      run(r, 0);
    end

    // Backpressure: held response, new request ignored
    run(tbl[1], 5);
    for (int k = 0; k < 3; k++) tick();
    chk("bp_no_extra_rsp", bus.rsp_valid, 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

`ifdef ALU_SEQ_STICKY_EN
    chk("sticky_set", sticky_ovf, 64'd1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_clr", sticky_ovf, 64'd0);
    run(tbl[0], 0);
    chk("sticky_no_ovf", sticky_ovf, 64'd0);
    sticky_clr = 1'b1;
    run(tbl[11], 0);
    sticky_clr = 1'b0;
    chk("sticky_set_wins", sticky_ovf, 64'd1);
`endif

    // Reset during the first EXEC pass abandons the operation
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_a     = tbl[0].a;
    bus.req_b     = tbl[0].b;
    bus.req_cin   = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_pass0_a", bus.alu_a, 64'hFFFFFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", bus.rsp_valid, 64'd0);
    chk("mid_rst_ready", bus.req_ready, 64'd1);
    chk("mid_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op},
        64'd0);
    for (int k = 0; k < NW + 2; k++) tick();
    chk("mid_rst_no_rsp", bus.rsp_valid, 64'd0);

    run(tbl[7], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
